genius_sequence_player: RTL and testbench

- Transmit side of the Genius colour-sequence path. Stores the game's colour sequence in an append-only buffer, then plays it back to the player as timed one-hot LED flashes.
- The button-capture registers are the receive side; this block produces the stimulus those registers are later compared against.
- Sits between the game-control FSM (writes colours, starts playback) and the LED pins.

---
 rtl/genius_pkg.sv | 24 ++
 rtl/genius_flash_timer.sv | 36 +++
 rtl/genius_sequence_player.sv | 180 ++++++++++++++++++
 tb/tb_genius_sequence_player.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/genius_pkg.sv
// Shared types for the Genius colour-sequence player: colour codes,
// playback states and the colour-to-LED decode.
package genius_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    RED    = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } color_t;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    GAP,
    DONE
  } play_state_t;

  // One LED per colour; bit position equals the colour code.
  function automatic logic [3:0] onehot_color(color_t c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/genius_flash_timer.sv
// Loadable down-counter used to time LED on and gap phases.
// tc_o is high while the count sits at zero; the counter parks there.
module genius_flash_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: a load overrides counting, otherwise decrement down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/genius_sequence_player.sv
// Genius colour-sequence player: append-only colour buffer plus a
// playback FSM that flashes each stored colour as a one-hot LED pattern.
module genius_sequence_player
  import genius_pkg::*;
#(
  parameter int COLOR_WIDTH = 2,
  parameter int MAX_LEN     = 32,
  parameter int ON_CYCLES   = 25_000_000,
  parameter int OFF_CYCLES  = 12_500_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [COLOR_WIDTH-1:0]       wr_color,
  input  logic                         clear,
  input  logic                         start,
  output logic [2**COLOR_WIDTH-1:0]    led,
  output logic                         busy,
  output logic                         done,
  output logic                         full,
  output logic [$clog2(MAX_LEN+1)-1:0] seq_len
);

  localparam int LED_W   = 2**COLOR_WIDTH;
  localparam int SEQ_W   = $clog2(MAX_LEN+1);
  localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_CYCLES - 1);

  play_state_t            state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [SEQ_W-1:0]       seq_len_q, seq_len_d;
  logic [LED_W-1:0]       led_q;
  logic                   busy_q;
  logic                   done_q;

  logic [COLOR_WIDTH-1:0] buf_q [MAX_LEN];
  logic                   buf_we;

  logic                   in_idle;
  logic                   start_go;
  logic                   on_end;
  logic                   gap_end;
  logic                   last_entry;
  logic                   tmr_load;
  logic [TMR_W-1:0]       tmr_val;
  logic                   tmr_tc;
  logic [IDX_W-1:0]       idx_nxt;
  logic [COLOR_WIDTH-1:0] nxt_color;
  logic [LED_W-1:0]       flash_pat;

  assign in_idle    = (state_q == IDLE);
  assign start_go   = in_idle && start;
  assign on_end     = (state_q == ON) && tmr_tc;
  assign gap_end    = (state_q == GAP) && tmr_tc;
  assign last_entry = ((SEQ_W'(idx_q) + SEQ_W'(1)) == seq_len_q);
  assign full       = (seq_len_q == SEQ_W'(MAX_LEN));

  // Timer is reloaded on entry to every ON or GAP phase.
  assign tmr_load = (start_go && (seq_len_q != '0)) || on_end || (gap_end && !last_entry);
  assign tmr_val  = on_end ? OFF_LOAD : ON_LOAD;

  // Colour shown by the next ON phase: entry 0 from IDLE, else the following entry.
  assign idx_nxt   = in_idle ? '0 : idx_q + IDX_W'(1);
  assign nxt_color = buf_q[idx_nxt];

  if (COLOR_WIDTH == 2) begin : g_pkg_onehot
    assign flash_pat = onehot_color(color_t'(nxt_color));
  end else begin : g_shift_onehot
    assign flash_pat = LED_W'(1) << nxt_color;
  end

  // A start accepted in IDLE takes priority over a same-cycle write or clear,
  // so the length being played never changes under the FSM.
  assign buf_we = in_idle && !start && !clear && wr_en && !full;

  // Sequence length: clear wins over write; frozen outside IDLE.
  always_comb begin
    seq_len_d = seq_len_q;
    if (in_idle && !start) begin
      if (clear) begin
        seq_len_d = '0;
      end else if (wr_en && !full) begin
        seq_len_d = seq_len_q + SEQ_W'(1);
      end
    end
  end

  // Length register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_len_q <= '0;
    end else begin
      seq_len_q <= seq_len_d;
    end
  end

  // Colour storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[seq_len_q[IDX_W-1:0]] <= wr_color;
    end
  end

  // Playback FSM with registered led/busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            if (seq_len_q != '0) begin
              state_q <= ON;
              idx_q   <= '0;
              led_q   <= flash_pat;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ON: begin
          if (tmr_tc) begin
            state_q <= GAP;
            led_q   <= '0;
          end
        end
        GAP: begin
          if (tmr_tc) begin
            if (last_entry) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ON;
              idx_q   <= idx_nxt;
              led_q   <= flash_pat;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          led_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  genius_flash_timer #(
    .WIDTH(TMR_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .tc_o      (tmr_tc)
  );

  assign led     = led_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign seq_len = seq_len_q;

endmodule

// File: tb/tb_genius_sequence_player.sv
// Bench for genius_sequence_player with short flash timings.
// A queue-based model predicts every output from the playback rules;
// directed scenarios add hand-computed literal expectations.
module tb_genius_sequence_player;

  localparam int ON   = 4;
  localparam int OFF  = 2;
  localparam int PER  = ON + OFF;
  localparam int MAXL = 4;
  localparam int REC  = 26;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       wr_en    = 1'b0;
  logic [1:0] wr_color = 2'd0;
  logic       clear    = 1'b0;
  logic       start    = 1'b0;
  logic [3:0] led;
  logic       busy;
  logic       done;
  logic       full;
  logic [2:0] seq_len;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  genius_sequence_player #(
    .COLOR_WIDTH(2),
    .MAX_LEN    (MAXL),
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_color(wr_color),
    .clear   (clear),
    .start   (start),
    .led     (led),
    .busy    (busy),
    .done    (done),
    .full    (full),
    .seq_len (seq_len)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stored colours as a queue; playback as a cycle index
  // k since the start edge (k=1 is the first cycle after it).
  int mq[$];
  bit m_active = 1'b0;
  int m_k = 0;
  int m_n = 0;
  int snap[MAXL];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_active = 1'b0;
      m_k = 0;
      m_n = 0;
    end else if (m_active) begin
      if (m_k == m_n * PER + 1) begin
        m_active = 1'b0;
        m_k = 0;
      end else begin
        m_k++;
      end
    end else if (start) begin
      m_active = 1'b1;
      m_k = 1;
      m_n = mq.size();
      for (int i = 0; i < MAXL; i++) snap[i] = (i < mq.size()) ? mq[i] : 0;
    end else if (clear) begin
      mq.delete();
    end else if (wr_en && mq.size() < MAXL) begin
      mq.push_back(int'(wr_color));
    end
  end

  // Compare every cycle against the model.
  always @(negedge clk) begin
    logic [3:0] e_led;
    logic       e_done;
    int         ent;
    int         ph;
    e_led  = 4'd0;
    e_done = 1'b0;
    if (m_active) begin
      if (m_k <= m_n * PER) begin
        ent = (m_k - 1) / PER;
        ph  = (m_k - 1) % PER;
        if (ph < ON) e_led = 4'(1 << snap[ent]);
      end else begin
        e_done = 1'b1;
      end
    end
    check("model_led", 32'(led), 32'(e_led));
    check("model_busy", 32'(busy), 32'(m_active));
    check("model_done", 32'(done), 32'(e_done));
    check("model_seq_len", 32'(seq_len), 32'(mq.size()));
    check("model_full", 32'(full), 32'(mq.size() == MAXL));
  end

  logic [3:0] rec_led  [1:REC];
  logic       rec_done [1:REC];
  logic       rec_busy [1:REC];

  task automatic cyc(input logic w, input logic [1:0] c, input logic cl, input logic st);
    wr_en = w; wr_color = c; clear = cl; start = st;
    @(posedge clk); #1;
    wr_en = 1'b0; clear = 1'b0; start = 1'b0;
  endtask

  // Record outputs for cycles t+1..t+REC after a start edge; optionally
  // throw control junk at the DUT while it cannot be in IDLE.
  task automatic play_record(input bit junk, input int junk_last);
    for (int k = 1; k <= REC; k++) begin
      if (junk && k <= junk_last) begin
        if (k == 3) begin
          wr_en = 1'b1; clear = 1'b1; start = 1'b1; wr_color = 2'd3;
        end else begin
          wr_en = 1'($urandom); clear = 1'($urandom); start = 1'($urandom);
          wr_color = 2'($urandom);
        end
      end else begin
        wr_en = 1'b0; clear = 1'b0; start = 1'b0;
      end
      @(negedge clk);
      rec_led[k]  = led;
      rec_done[k] = done;
      rec_busy[k] = busy;
      @(posedge clk); #1;
    end
    wr_en = 1'b0; clear = 1'b0; start = 1'b0;
  endtask

  // RED, BLUE, GREEN playback timing, hand-computed.
  task automatic check_rbg(input string tag);
    int nd;
    check({tag, "_led_t1"},  32'(rec_led[1]),  32'h2);
    check({tag, "_led_t4"},  32'(rec_led[4]),  32'h2);
    check({tag, "_led_t5"},  32'(rec_led[5]),  32'h0);
    check({tag, "_led_t6"},  32'(rec_led[6]),  32'h0);
    check({tag, "_led_t7"},  32'(rec_led[7]),  32'h4);
    check({tag, "_led_t10"}, 32'(rec_led[10]), 32'h4);
    check({tag, "_led_t11"}, 32'(rec_led[11]), 32'h0);
    check({tag, "_led_t13"}, 32'(rec_led[13]), 32'h1);
    check({tag, "_led_t16"}, 32'(rec_led[16]), 32'h1);
    check({tag, "_led_t17"}, 32'(rec_led[17]), 32'h0);
    check({tag, "_done_t18"}, 32'(rec_done[18]), 32'h0);
    check({tag, "_done_t19"}, 32'(rec_done[19]), 32'h1);
    check({tag, "_busy_t19"}, 32'(rec_busy[19]), 32'h1);
    check({tag, "_busy_t20"}, 32'(rec_busy[20]), 32'h0);
    nd = 0;
    for (int k = 1; k <= REC; k++) nd += int'(rec_done[k]);
    check({tag, "_done_count"}, 32'(nd), 32'd1);
  endtask

  initial begin
    int r;
    logic [3:0] any_led;

    // Reset then idle
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_led", 32'(led), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_seq_len", 32'(seq_len), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Write RED, BLUE, GREEN and play
    cyc(1'b1, 2'd1, 1'b0, 1'b0);
    cyc(1'b1, 2'd2, 1'b0, 1'b0);
    cyc(1'b1, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    play_record(1'b0, 0);
    check_rbg("play");

    // Same playback with controls pulsed throughout
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    play_record(1'b1, 19);
    check_rbg("ignore");
    @(negedge clk);
    check("ignore_seq_len", 32'(seq_len), 32'd3);
    @(posedge clk); #1;

    // Fill beyond capacity
    cyc(1'b0, 2'd0, 1'b1, 1'b0);
    cyc(1'b1, 2'd3, 1'b0, 1'b0);
    cyc(1'b1, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 2'd1, 1'b0, 1'b0);
    cyc(1'b1, 2'd2, 1'b0, 1'b0);
    @(negedge clk);
    check("full_seq_len4", 32'(seq_len), 32'd4);
    check("full_flag", 32'(full), 32'd1);
    @(posedge clk); #1;
    cyc(1'b1, 2'd1, 1'b0, 1'b0);
    @(negedge clk);
    check("full_5th_ignored", 32'(seq_len), 32'd4);
    @(posedge clk); #1;
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    play_record(1'b0, 0);
    check("full_first_flash", 32'(rec_led[1]), 32'h8);
    check("full_second_flash", 32'(rec_led[7]), 32'h1);
    check("full_fourth_flash", 32'(rec_led[19]), 32'h4);
    check("full_done_t25", 32'(rec_done[25]), 32'h1);

    // Empty start
    cyc(1'b0, 2'd0, 1'b1, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    play_record(1'b0, 0);
    check("empty_done_t1", 32'(rec_done[1]), 32'h1);
    check("empty_busy_t1", 32'(rec_busy[1]), 32'h1);
    check("empty_busy_t2", 32'(rec_busy[2]), 32'h0);
    any_led = 4'd0;
    for (int k = 1; k <= REC; k++) any_led = any_led | rec_led[k];
    check("empty_no_led", 32'(any_led), 32'h0);

    // Same-cycle clear and write in IDLE
    cyc(1'b1, 2'd3, 1'b0, 1'b0);
    cyc(1'b1, 2'd1, 1'b1, 1'b0);
    @(negedge clk);
    check("clear_wins", 32'(seq_len), 32'd0);
    @(posedge clk); #1;

    // Asynchronous abort mid-ON
    cyc(1'b1, 2'd1, 1'b0, 1'b0);
    cyc(1'b1, 2'd2, 1'b0, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    @(posedge clk); #2;
    check("abort_lit_before", 32'(led), 32'h2);
    rst_n = 1'b0;
    #1;
    check("abort_led", 32'(led), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort_seq_len", 32'(seq_len), 32'd0);
    check("abort_idle_busy", 32'(busy), 32'h0);
    check("abort_idle_led", 32'(led), 32'h0);
    @(posedge clk); #1;

    // Randomised traffic, one control action per cycle
    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 11));
      wr_color = 2'($urandom);
      wr_en = (r <= 5) || (r == 7);
      clear = (r == 6) || (r == 7);
      start = (r == 8) || (r == 9);
      @(posedge clk); #1;
      wr_en = 1'b0; clear = 1'b0; start = 1'b0;
    end
    repeat (30) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
